// File: rtl/fir_mac_engine_if.sv
// Streaming sample interface for fir_mac_engine: input frames in, filtered frames out,
// rts/rtr handshake on each side.
interface fir_mac_engine_if #(
   parameter int unsigned NCH = 2,
   parameter int unsigned DW  = 16
) ();
   logic                in_rts;
   logic                in_rtr;
   logic [NCH*DW-1:0]   in_data;
   logic                out_rts;
   logic                out_rtr;
   logic [NCH*DW-1:0]   out_data;

   // Engine side
   modport slave (
      input  in_rts, in_data, out_rtr,
      output in_rtr, out_rts, out_data
   );

   // Source/sink side
   modport master (
      output in_rts, in_data, out_rtr,
      input  in_rtr, out_rts, out_data
   );
endinterface

// File: rtl/fir_mac_engine.sv
// Multi-channel time-domain FIR: shared coefficients, circular sample history,
// one MAC per channel, round/shift/saturate output stage, bypass and flush.
module fir_mac_engine #(
   parameter int unsigned NCH   = 2,
   parameter int unsigned DW    = 16,
   parameter int unsigned CW    = 16,
   parameter int unsigned PTR   = 9,
   parameter int unsigned GUARD = 8
) (
   input  logic               clk,
   input  logic               rstb,
   fir_mac_engine_if.slave    io,
   output logic               coef_re,
   output logic [PTR-1:0]     coef_addr,
   input  logic [CW-1:0]      coef_data,
   input  logic [PTR-1:0]     rf_taps_m1,
   input  logic [3:0]         rf_shift,
   input  logic               rf_sat,
   input  logic               rf_bypass,
   input  logic               trig_flush,
   input  logic               trig_ovf_clear,
   output logic [NCH-1:0]     ro_ovf_flag,
   output logic               busy
);
   localparam int unsigned AW   = DW + CW + GUARD;
   localparam int unsigned TAPS = 2 ** PTR;
   localparam int unsigned FW   = NCH * DW;
   localparam logic signed [AW:0] SMAX = {{(AW + 2 - DW){1'b0}}, {(DW - 1){1'b1}}};
   localparam logic signed [AW:0] SMIN = {{(AW + 2 - DW){1'b1}}, {(DW - 1){1'b0}}};

   typedef enum logic [2:0] {S_FLUSH, S_IDLE, S_MAC, S_DRAIN, S_ROUND, S_OUT} state_e;

   state_e            state_q, state_d;
   logic              in_rtr_q, in_rtr_d;
   logic              out_rts_q, out_rts_d;
   logic [FW-1:0]     out_data_q, out_data_d;
   logic              coef_re_q, coef_re_d;
   logic [PTR-1:0]    coef_addr_q, coef_addr_d;
   logic [NCH-1:0]    ovf_q, ovf_d;
   logic              busy_q, busy_d;
   logic [PTR-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR-1:0]    fcnt_q, fcnt_d;
   logic              pend_q, pend_d;
   logic [PTR-1:0]    taps_q, taps_d;

   logic [FW-1:0]          hist_q [TAPS];
   logic [FW-1:0]          rd_q;
   logic                   mac_v_q, first_q;
   logic signed [AW-1:0]   acc_q [NCH];
   logic signed [AW-1:0]   pext [NCH];
   logic [FW-1:0]          rnd_data;
   logic [NCH-1:0]         rnd_ovf;
   logic [PTR-1:0]         rd_addr;
   logic                   accept;

   assign accept  = (state_q == S_IDLE) && io.in_rts && in_rtr_q;
   assign rd_addr = wr_ptr_q - coef_addr_q;

   assign io.in_rtr   = in_rtr_q;
   assign io.out_rts  = out_rts_q;
   assign io.out_data = out_data_q;
   assign coef_re     = coef_re_q;
   assign coef_addr   = coef_addr_q;
   assign ro_ovf_flag = ovf_q;
   assign busy        = busy_q;

   // History RAM: flush writes, accepted samples, registered read for the MAC
   always_ff @(posedge clk) begin
      if (state_q == S_FLUSH) hist_q[fcnt_q] <= '0;
      else if (accept)        hist_q[wr_ptr_q] <= io.in_data;
      rd_q <= hist_q[rd_addr];
   end

   // Products sign-extended to accumulator width
   always_comb begin
      logic signed [DW-1:0] x_v;
      logic signed [CW-1:0] h_v;
      logic signed [DW+CW-1:0] p_v;
      x_v = '0;
      h_v = coef_data;
      p_v = '0;
      for (int c = 0; c < NCH; c++) begin
         x_v     = rd_q[c*DW +: DW];
         p_v     = x_v * h_v;
         pext[c] = AW'(p_v);
      end
   end

   // Accumulators: data and coefficient arrive one cycle after the MAC address cycle
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         mac_v_q <= 1'b0;
         first_q <= 1'b0;
         for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
      end else begin
         mac_v_q <= (state_q == S_MAC);
         first_q <= (state_q == S_MAC) && (coef_addr_q == '0);
         if (mac_v_q) begin
            for (int c = 0; c < NCH; c++)
               acc_q[c] <= first_q ? pext[c] : acc_q[c] + pext[c];
         end
      end
   end

   // Round half-up, shift, then saturate or wrap per channel
   always_comb begin
      logic signed [AW:0] sum_v;
      logic signed [AW:0] t_v;
      int unsigned s_v;
      rnd_data = '0;
      rnd_ovf  = '0;
      sum_v    = '0;
      t_v      = '0;
      s_v      = (32'(rf_shift) > CW - 2) ? CW - 2 : 32'(rf_shift);
      for (int c = 0; c < NCH; c++) begin
         sum_v = {acc_q[c][AW-1], acc_q[c]} + ((AW + 1)'(1) << (CW - 2 - s_v));
         t_v   = sum_v >>> (CW - 1 - s_v);
         rnd_data[c*DW +: DW] = t_v[DW-1:0];
         if (t_v > SMAX) begin
            rnd_ovf[c] = 1'b1;
            if (rf_sat) rnd_data[c*DW +: DW] = SMAX[DW-1:0];
         end else if (t_v < SMIN) begin
            rnd_ovf[c] = 1'b1;
            if (rf_sat) rnd_data[c*DW +: DW] = SMIN[DW-1:0];
         end
      end
   end

   // FSM state and registered outputs
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q     <= S_FLUSH;
         in_rtr_q    <= 1'b0;
         out_rts_q   <= 1'b0;
         out_data_q  <= '0;
         coef_re_q   <= 1'b0;
         coef_addr_q <= '0;
         ovf_q       <= '0;
         busy_q      <= 1'b1;
         wr_ptr_q    <= '0;
         fcnt_q      <= '0;
         pend_q      <= 1'b0;
         taps_q      <= '0;
      end else begin
         state_q     <= state_d;
         in_rtr_q    <= in_rtr_d;
         out_rts_q   <= out_rts_d;
         out_data_q  <= out_data_d;
         coef_re_q   <= coef_re_d;
         coef_addr_q <= coef_addr_d;
         ovf_q       <= ovf_d;
         busy_q      <= busy_d;
         wr_ptr_q    <= wr_ptr_d;
         fcnt_q      <= fcnt_d;
         pend_q      <= pend_d;
         taps_q      <= taps_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      in_rtr_d    = 1'b0;
      out_rts_d   = out_rts_q;
      out_data_d  = out_data_q;
      coef_re_d   = 1'b0;
      coef_addr_d = '0;
      ovf_d       = ovf_q & ~{NCH{trig_ovf_clear}};
      busy_d      = 1'b1;
      wr_ptr_d    = wr_ptr_q;
      fcnt_d      = fcnt_q;
      pend_d      = pend_q | trig_flush;
      taps_d      = taps_q;
      case (state_q)
         S_FLUSH: begin
            fcnt_d = fcnt_q + PTR'(1);
            if (fcnt_q == PTR'(TAPS - 1)) state_d = S_IDLE;
         end
         S_IDLE: begin
            if (accept) begin
               taps_d = rf_taps_m1;
               if (rf_bypass) begin
                  out_data_d = io.in_data;
                  out_rts_d  = 1'b1;
                  state_d    = S_OUT;
               end else begin
                  coef_re_d = 1'b1;
                  state_d   = S_MAC;
               end
            end else if (pend_q) begin
               pend_d  = trig_flush;
               state_d = S_FLUSH;
            end
         end
         S_MAC: begin
            if (coef_addr_q == taps_q) begin
               state_d = S_DRAIN;
            end else begin
               coef_re_d   = 1'b1;
               coef_addr_d = coef_addr_q + PTR'(1);
            end
         end
         S_DRAIN: state_d = S_ROUND;
         S_ROUND: begin
            out_data_d = rnd_data;
            ovf_d      = ovf_d | rnd_ovf;
            out_rts_d  = 1'b1;
            state_d    = S_OUT;
         end
         S_OUT: begin
            if (io.out_rtr) begin
               out_rts_d = 1'b0;
               wr_ptr_d  = wr_ptr_q + PTR'(1);
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_FLUSH;
      endcase
      // A pending flush withholds ready so IDLE can leave for FLUSH cleanly
      in_rtr_d = (state_d == S_IDLE) && !pend_d;
      busy_d   = (state_d != S_IDLE);
   end
endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine: flush timing, impulse response, latency,
// rounding/shift clamp, wrap and saturate, backpressure, bypass, reset mid-frame.
module tb_fir_mac_engine;
   localparam int unsigned NCH = 2, DW = 16, CW = 16, PTR = 3, GUARD = 8;

   logic            clk = 1'b0;
   logic            rstb;
   logic            coef_re;
   logic [PTR-1:0]  coef_addr;
   logic [CW-1:0]   coef_data;
   logic [PTR-1:0]  rf_taps_m1;
   logic [3:0]      rf_shift;
   logic            rf_sat, rf_bypass, trig_flush, trig_ovf_clear;
   logic [NCH-1:0]  ro_ovf_flag;
   logic            busy;
   logic [CW-1:0]   coef_mem [8];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fir_mac_engine_if #(.NCH(NCH), .DW(DW)) io ();

   fir_mac_engine #(.NCH(NCH), .DW(DW), .CW(CW), .PTR(PTR), .GUARD(GUARD)) dut (
      .clk(clk), .rstb(rstb), .io(io),
      .coef_re(coef_re), .coef_addr(coef_addr), .coef_data(coef_data),
      .rf_taps_m1(rf_taps_m1), .rf_shift(rf_shift), .rf_sat(rf_sat),
      .rf_bypass(rf_bypass), .trig_flush(trig_flush), .trig_ovf_clear(trig_ovf_clear),
      .ro_ovf_flag(ro_ovf_flag), .busy(busy)
   );

   // Coefficient ROM with one-cycle read latency
   always @(posedge clk) if (coef_re) coef_data <= coef_mem[coef_addr];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_coefs(input logic [CW-1:0] v);
      for (int i = 0; i < 8; i++) coef_mem[i] = v;
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_in_rtr"},   64'(io.in_rtr),   64'(0));
      check({tag, "_out_rts"},  64'(io.out_rts),  64'(0));
      check({tag, "_out_data"}, 64'(io.out_data), 64'(0));
      check({tag, "_busy"},     64'(busy),        64'(1));
      check({tag, "_coef_re"},  64'(coef_re),     64'(0));
      check({tag, "_coef_addr"},64'(coef_addr),   64'(0));
      check({tag, "_ovf"},      64'(ro_ovf_flag), 64'(0));
   endtask

   task automatic release_and_flush(input string tag);
      int n = 0;
      int seen = 0;
      rstb = 1'b1;
      while (io.in_rtr !== 1'b1 && n < 50) begin
         tick();
         n++;
         if (coef_re === 1'b1) seen++;
      end
      check({tag, "_flush_cycles"}, 64'(n), 64'(8));
      check({tag, "_busy_idle"},    64'(busy), 64'(0));
      check({tag, "_coef_re_seen"}, 64'(seen), 64'(0));
   endtask

   task automatic wait_rtr();
      int n = 0;
      while (io.in_rtr !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) check("in_rtr_timeout", 64'(io.in_rtr), 64'(1));
   endtask

   // Accept one frame, measure latency to out_rts and the coefficient address sequence
   task automatic run_frame(input string tag, input logic [31:0] din, input logic [31:0] dexp,
                            input int exp_lat, input int exp_ncoef);
      int lat, k, bad;
      wait_rtr();
      io.in_data = din;
      io.in_rts  = 1'b1;
      tick();
      io.in_rts  = 1'b0;
      lat = 1; k = 0; bad = 0;
      while (io.out_rts !== 1'b1 && lat < 100) begin
         if (coef_re === 1'b1) begin
            if (coef_addr !== PTR'(k)) bad++;
            k++;
         end
         tick();
         lat++;
      end
      check({tag, "_latency"},  64'(lat),         64'(exp_lat));
      check({tag, "_out_data"}, 64'(io.out_data), 64'(dexp));
      check({tag, "_ncoef"},    64'(k),           64'(exp_ncoef));
      check({tag, "_coef_seq"}, 64'(bad),         64'(0));
   endtask

   task automatic pulse_flush();
      wait_rtr();
      trig_flush = 1'b1;
      tick();
      trig_flush = 1'b0;
   endtask

   initial begin
      int bp_bad;
      io.in_rts = 1'b0; io.in_data = '0; io.out_rtr = 1'b1;
      rstb = 1'b0; rf_taps_m1 = 3'd3; rf_shift = 4'd0; rf_sat = 1'b1; rf_bypass = 1'b0;
      trig_flush = 1'b0; trig_ovf_clear = 1'b0;
      set_coefs(16'h4000);
      repeat (3) @(posedge clk);
      #1;
      check_reset("por");
      release_and_flush("por");

      // Impulse through 4 taps of 0.5: four echoes, then silence
      run_frame("imp0", 32'h2000_1000, 32'h1000_0800, 7, 4);
      run_frame("imp1", 32'h0000_0000, 32'h1000_0800, 7, 4);
      run_frame("imp2", 32'h0000_0000, 32'h1000_0800, 7, 4);
      run_frame("imp3", 32'h0000_0000, 32'h1000_0800, 7, 4);
      run_frame("imp4", 32'h0000_0000, 32'h0000_0000, 7, 4);

      pulse_flush();
      tick();
      tick();
      check("flush_busy",   64'(busy),      64'(1));
      check("flush_in_rtr", 64'(io.in_rtr), 64'(0));

      // Eight taps on a flushed history, positive and negative channel
      rf_taps_m1 = 3'd7;
      run_frame("n7", 32'h4000_C000, 32'h2000_E000, 11, 8);

      // Shift 15 clamps to 14
      rf_taps_m1 = 3'd0;
      rf_shift   = 4'd15;
      run_frame("shclamp", 32'h0003_0001, 32'h6000_2000, 4, 1);
      check("shclamp_ovf", 64'(ro_ovf_flag), 64'(0));

      // Wrap mode keeps low bits and flags the channel
      rf_shift = 4'd14;
      rf_sat   = 1'b0;
      run_frame("wrap", 32'h0000_7FFF, 32'h0000_E000, 4, 1);
      check("wrap_ovf", 64'(ro_ovf_flag), 64'(2'b01));
      trig_ovf_clear = 1'b1;
      tick();
      trig_ovf_clear = 1'b0;
      check("wrap_ovf_clr", 64'(ro_ovf_flag), 64'(0));

      // Full-scale input and coefficients: first frame fits, later ones saturate
      rf_shift = 4'd0; rf_sat = 1'b1; rf_taps_m1 = 3'd7;
      set_coefs(16'h7FFF);
      pulse_flush();
      run_frame("sat1", 32'h7FFF_7FFF, 32'h7FFE_7FFE, 11, 8);
      check("sat1_ovf", 64'(ro_ovf_flag), 64'(0));
      for (int i = 2; i <= 8; i++)
         run_frame($sformatf("sat%0d", i), 32'h7FFF_7FFF, 32'h7FFF_7FFF, 11, 8);
      check("sat_ovf", 64'(ro_ovf_flag), 64'(2'b11));
      trig_ovf_clear = 1'b1;
      tick();
      trig_ovf_clear = 1'b0;
      check("sat_ovf_clr", 64'(ro_ovf_flag), 64'(0));

      // Downstream backpressure holds the frame and blocks input
      io.out_rtr = 1'b0;
      run_frame("bp", 32'h7FFF_7FFF, 32'h7FFF_7FFF, 11, 8);
      bp_bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (io.out_rts !== 1'b1 || io.out_data !== 32'h7FFF_7FFF || io.in_rtr !== 1'b0)
            bp_bad++;
      end
      check("bp_hold", 64'(bp_bad), 64'(0));
      io.out_rtr = 1'b1;
      tick();
      check("bp_out_rts_drop", 64'(io.out_rts), 64'(0));
      check("bp_in_rtr_back",  64'(io.in_rtr),  64'(1));

      // Bypass passes the frame straight through
      rf_bypass = 1'b1;
      run_frame("byp", 32'h1234_ABCD, 32'h1234_ABCD, 1, 0);
      check("byp_ovf", 64'(ro_ovf_flag), 64'(2'b11));
      rf_bypass = 1'b0;

      // Reset in the middle of a MAC frame
      wait_rtr();
      io.in_data = 32'h7FFF_7FFF;
      io.in_rts  = 1'b1;
      tick();
      io.in_rts  = 1'b0;
      tick();
      tick();
      check("mid_coef_re", 64'(coef_re), 64'(1));
      rstb = 1'b0;
      #1;
      check_reset("mid");
      tick();
      release_and_flush("mid");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
